// File: rtl/solar_tracker_sched.sv
// rtl/solar_tracker_sched.sv - ADC sweep sequencer and sun-tracking motor controller
module solar_tracker_sched #(
    parameter int TH       = 10,
    parameter int SETTLE   = 4,
    parameter int MOVE_MAX = 255,
    parameter int COOLDOWN = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] adc_sel_o,
    output logic       adc_start_o,
    input  logic       adc_done_i,
    input  logic [7:0] adc_data_i,
    output logic [7:0] lsn_o,
    output logic [7:0] lse_o,
    output logic [7:0] lss_o,
    output logic [7:0] lsw_o,
    output logic       sample_valid_o,
    output logic       mn_o,
    output logic       me_o,
    output logic       ms_o,
    output logic       mw_o,
    output logic       fault_o
);
    localparam int SCW = $clog2(SETTLE + 1);
    localparam int MVW = $clog2(MOVE_MAX + 1);
    localparam int CW  = $clog2(COOLDOWN + 1);

    typedef enum logic [1:0] {S_SETTLE, S_START, S_WAIT} scan_t;
    typedef enum logic [2:0] {M_IDLE, M_N, M_E, M_S, M_W, M_COOL, M_FAULT} mot_t;

    scan_t           scan_q, scan_d;
    logic [SCW-1:0]  set_cnt_q, set_cnt_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0][7:0] ls_q, ls_d;
    logic            sv_q, sv_d;
    mot_t            mot_q, mot_d;
    logic [MVW-1:0]  mv_q, mv_d;
    logic [CW-1:0]   cool_q, cool_d;
    logic            balanced;
    logic            n_gt, e_gt, s_gt, w_gt;

    always_comb begin
        scan_d    = scan_q;
        set_cnt_d = set_cnt_q;
        sel_d     = sel_q;
        ls_d      = ls_q;
        sv_d      = 1'b0;
        case (scan_q)
            S_SETTLE: begin
                if (set_cnt_q == SCW'(SETTLE - 1)) begin
                    scan_d    = S_START;
                    set_cnt_d = '0;
                end else begin
                    set_cnt_d = set_cnt_q + SCW'(1);
                end
            end
            S_START: scan_d = S_WAIT;
            S_WAIT: begin
                if (adc_done_i) begin
                    ls_d[sel_q] = adc_data_i;
                    sv_d        = (sel_q == 2'd3);
                    sel_d       = sel_q + 2'd1;
                    scan_d      = S_SETTLE;
                end
            end
            default: scan_d = S_SETTLE;
        endcase
    end

    // Widened to 9 bits so x + TH never wraps around to a small value.
    assign n_gt = {1'b0, ls_q[0]} > ({1'b0, ls_q[2]} + 9'(TH));
    assign e_gt = {1'b0, ls_q[1]} > ({1'b0, ls_q[3]} + 9'(TH));
    assign s_gt = {1'b0, ls_q[2]} > ({1'b0, ls_q[0]} + 9'(TH));
    assign w_gt = {1'b0, ls_q[3]} > ({1'b0, ls_q[1]} + 9'(TH));

    always_comb begin
        mot_d    = mot_q;
        mv_d     = mv_q;
        cool_d   = cool_q;
        balanced = 1'b0;
        case (mot_q)
            M_N:     balanced = ls_q[0] <= ls_q[2];
            M_E:     balanced = ls_q[1] <= ls_q[3];
            M_S:     balanced = ls_q[2] <= ls_q[0];
            M_W:     balanced = ls_q[3] <= ls_q[1];
            default: balanced = 1'b0;
        endcase
        case (mot_q)
            M_IDLE: begin
                if (sv_q) begin
                    mv_d = '0;
                    if (n_gt)      mot_d = M_N;
                    else if (e_gt) mot_d = M_E;
                    else if (s_gt) mot_d = M_S;
                    else if (w_gt) mot_d = M_W;
                end
            end
            M_N, M_E, M_S, M_W: begin
                // Timeout is tested first so it wins over a simultaneous balance.
                if (mv_q == MVW'(MOVE_MAX - 1)) begin
                    mot_d = M_FAULT;
                end else begin
                    mv_d = mv_q + MVW'(1);
                    if (sv_q && balanced) begin
                        mot_d  = M_COOL;
                        cool_d = '0;
                    end
                end
            end
            M_COOL: begin
                if (cool_q == CW'(COOLDOWN - 1)) mot_d = M_IDLE;
                else cool_d = cool_q + CW'(1);
            end
            M_FAULT: mot_d = M_FAULT;
            default: mot_d = M_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q    <= S_SETTLE;
            set_cnt_q <= '0;
            sel_q     <= '0;
            ls_q      <= '0;
            sv_q      <= 1'b0;
            mot_q     <= M_IDLE;
            mv_q      <= '0;
            cool_q    <= '0;
        end else begin
            scan_q    <= scan_d;
            set_cnt_q <= set_cnt_d;
            sel_q     <= sel_d;
            ls_q      <= ls_d;
            sv_q      <= sv_d;
            mot_q     <= mot_d;
            mv_q      <= mv_d;
            cool_q    <= cool_d;
        end
    end

    assign adc_sel_o      = sel_q;
    assign adc_start_o    = (scan_q == S_START);
    assign lsn_o          = ls_q[0];
    assign lse_o          = ls_q[1];
    assign lss_o          = ls_q[2];
    assign lsw_o          = ls_q[3];
    assign sample_valid_o = sv_q;
    assign mn_o           = (mot_q == M_N);
    assign me_o           = (mot_q == M_E);
    assign ms_o           = (mot_q == M_S);
    assign mw_o           = (mot_q == M_W);
    assign fault_o        = (mot_q == M_FAULT);
endmodule

// File: tb/tb_solar_tracker_sched.sv
// tb/tb_solar_tracker_sched.sv - scoreboard bench for solar_tracker_sched
module tb_solar_tracker_sched;
    localparam int SETTLE = 4;

    logic       clk, rst;
    logic       m_done, f_done;
    logic [7:0] m_data, f_data;
    logic [1:0] m_sel, f_sel;
    logic       m_start, f_start, m_sv, f_sv, m_fault, f_fault;
    logic [7:0] m_lsn, m_lse, m_lss, m_lsw, f_lsn, f_lse, f_lss, f_lsw;
    logic       m_mn, m_me, m_ms, m_mw, f_mn, f_me, f_ms, f_mw;

    solar_tracker_sched #(.TH(10), .SETTLE(SETTLE), .MOVE_MAX(255), .COOLDOWN(40)) u_main (
        .clk(clk), .rst(rst), .adc_sel_o(m_sel), .adc_start_o(m_start),
        .adc_done_i(m_done), .adc_data_i(m_data),
        .lsn_o(m_lsn), .lse_o(m_lse), .lss_o(m_lss), .lsw_o(m_lsw),
        .sample_valid_o(m_sv), .mn_o(m_mn), .me_o(m_me), .ms_o(m_ms), .mw_o(m_mw),
        .fault_o(m_fault)
    );

    solar_tracker_sched #(.TH(10), .SETTLE(SETTLE), .MOVE_MAX(8), .COOLDOWN(16)) u_flt (
        .clk(clk), .rst(rst), .adc_sel_o(f_sel), .adc_start_o(f_start),
        .adc_done_i(f_done), .adc_data_i(f_data),
        .lsn_o(f_lsn), .lse_o(f_lse), .lss_o(f_lss), .lsw_o(f_lsw),
        .sample_valid_o(f_sv), .mn_o(f_mn), .me_o(f_me), .ms_o(f_ms), .mw_o(f_mw),
        .fault_o(f_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic        cur;
    logic        c_start, c_sv;
    logic [1:0]  c_sel;
    logic [31:0] c_ls;
    logic [3:0]  c_mot;
    assign c_start = cur ? f_start : m_start;
    assign c_sv    = cur ? f_sv : m_sv;
    assign c_sel   = cur ? f_sel : m_sel;
    assign c_ls    = cur ? {f_lsw, f_lss, f_lse, f_lsn} : {m_lsw, m_lss, m_lse, m_lsn};
    assign c_mot   = cur ? {f_mn, f_me, f_ms, f_mw} : {m_mn, m_me, m_ms, m_mw};

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] n, e, s, w;
        logic [3:0] mot;
    } exp_t;
    exp_t sbq[$];

    // {N, E, S, W, expected {mn,me,ms,mw} one cycle after sample_valid}; main instance COOLDOWN=40
    localparam logic [35:0] TBL [22] = '{
        {8'd100, 8'd50, 8'd40,  8'd50, 4'b1000},
        {8'd60,  8'd50, 8'd60,  8'd50, 4'b0000},
        {8'd200, 8'd0,  8'd0,   8'd0,  4'b0000},
        {8'd200, 8'd0,  8'd0,   8'd0,  4'b1000},
        {8'd50,  8'd0,  8'd50,  8'd0,  4'b0000},
        {8'd20,  8'd0,  8'd10,  8'd0,  4'b0000},
        {8'd20,  8'd0,  8'd10,  8'd0,  4'b0000},
        {8'd21,  8'd0,  8'd10,  8'd0,  4'b1000},
        {8'd10,  8'd0,  8'd10,  8'd0,  4'b0000},
        {8'd255, 8'd0,  8'd250, 8'd0,  4'b0000},
        {8'd255, 8'd0,  8'd250, 8'd0,  4'b0000},
        {8'd90,  8'd90, 8'd0,   8'd0,  4'b1000},
        {8'd0,   8'd90, 8'd0,   8'd0,  4'b0000},
        {8'd0,   8'd90, 8'd0,   8'd0,  4'b0000},
        {8'd0,   8'd90, 8'd0,   8'd0,  4'b0100},
        {8'd0,   8'd0,  8'd0,   8'd0,  4'b0000},
        {8'd0,   8'd0,  8'd0,   8'd0,  4'b0000},
        {8'd0,   8'd0,  8'd0,   8'd50, 4'b0001},
        {8'd0,   8'd0,  8'd0,   8'd0,  4'b0000},
        {8'd0,   8'd0,  8'd0,   8'd0,  4'b0000},
        {8'd0,   8'd0,  8'd50,  8'd0,  4'b0010},
        {8'd0,   8'd0,  8'd50,  8'd0,  4'b0010}
    };

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (c_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("adc_start_timeout", 0, 1);
    endtask

    task automatic drive_done(input logic [7:0] d);
        @(negedge clk);
        if (cur) begin
            f_done = 1'b1;
            f_data = d;
        end else begin
            m_done = 1'b1;
            m_data = d;
        end
        @(negedge clk);
        f_done = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic sweep(input logic [7:0] n, input logic [7:0] e, input logic [7:0] s,
                         input logic [7:0] w, input logic [3:0] mot);
        exp_t       x;
        logic [7:0] v [4];
        bit         ok;
        int         k;
        x.n = n; x.e = e; x.s = s; x.w = w; x.mot = mot;
        sbq.push_back(x);
        v[0] = n; v[1] = e; v[2] = s; v[3] = w;
        for (int i = 0; i < 4; i++) begin
            wait_start(ok);
            if (!ok) break;
            check_eq("adc_sel", c_sel, i);
            drive_done(v[i]);
        end
        k = 0;
        while (!c_sv && k < 8) begin
            @(negedge clk);
            k++;
        end
        x = sbq.pop_front();
        check_eq("sample_valid", c_sv, 1);
        check_eq("lsn", c_ls[7:0], x.n);
        check_eq("lse", c_ls[15:8], x.e);
        check_eq("lss", c_ls[23:16], x.s);
        check_eq("lsw", c_ls[31:24], x.w);
        @(negedge clk);
        check_eq("motors", c_mot, x.mot);
        check_eq("sample_valid_width", c_sv, 0);
    endtask

    initial begin
        bit          ok;
        int          cycles;
        logic [35:0] t;
        cur = 1'b0;
        rst = 1'b1;
        m_done = 1'b0; m_data = 8'd0;
        f_done = 1'b0; f_data = 8'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_sel", m_sel, 0);
        check_eq("rst_start", m_start, 0);
        check_eq("rst_ls", {m_lsn, m_lse, m_lss, m_lsw}, 0);
        check_eq("rst_sv", m_sv, 0);
        check_eq("rst_motors", {m_mn, m_me, m_ms, m_mw}, 0);
        check_eq("rst_fault", m_fault, 0);
        rst = 1'b0;

        // Reset in the middle of the third conversion, then a stale adc_done.
        wait_start(ok);
        drive_done(8'd11);
        wait_start(ok);
        drive_done(8'd22);
        wait_start(ok);
        @(negedge clk);
        check_eq("wait_sel2", m_sel, 2);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_start", m_start, 0);
        check_eq("rst_mid_sel", m_sel, 0);
        rst = 1'b0;
        m_done = 1'b1;
        m_data = 8'hAB;
        cycles = 1;
        while (!m_start && cycles < 40) begin
            @(negedge clk);
            m_done = 1'b0;
            cycles++;
        end
        check_eq("start_latency", cycles, SETTLE + 1);
        check_eq("late_done_ignored", {m_lsn, m_lse, m_lss, m_lsw}, 0);
        check_eq("post_rst_sel", m_sel, 0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 22; i++) begin
            t = TBL[i];
            sweep(t[35:28], t[27:20], t[19:12], t[11:4], t[3:0]);
        end

        // Timeout path on the MOVE_MAX=8 instance.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cur = 1'b1;
        sweep(8'd100, 8'd0, 8'd0, 8'd0, 4'b1000);
        fork
            sweep(8'd100, 8'd0, 8'd0, 8'd0, 4'b0000);
            begin
                int cnt;
                cnt = 1;
                for (int k = 0; k < 30; k++) begin
                    @(negedge clk);
                    if (f_mn) cnt++;
                    else break;
                end
                check_eq("move_max_cycles", cnt, 8);
                check_eq("fault_set", f_fault, 1);
            end
        join
        check_eq("fault_sticky", f_fault, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("fault_cleared", f_fault, 0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
